// File: rtl/axil_reg_responder_pkg.sv
// axil_reg_pkg: response codes, FSM states and address decode for the AXI-Lite register responder
package axil_reg_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [11:0] RO_BASE_OFFSET = 12'h100;
  localparam int ADDR_LSB = 2;
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef struct packed {
    logic hit_rw;
    logic hit_ro;
    logic [5:0] index;
    logic err;
  } dec_t;
  // Upper address bits are masked off, so aliases of the register window decode identically.
  function automatic dec_t decode(input logic [31:0] addr, input logic [31:0] mask,
                                  input logic [31:0] num_rw, input logic [31:0] num_ro);
    logic [31:0] off;
    logic [31:0] ro;
    dec_t d;
    off = addr & mask;
    ro = off - {20'd0, RO_BASE_OFFSET};
    d.hit_rw = off[ADDR_LSB-1:0] == '0 && off < (num_rw << ADDR_LSB);
    d.hit_ro = off[ADDR_LSB-1:0] == '0 && off >= {20'd0, RO_BASE_OFFSET} && ro < (num_ro << ADDR_LSB);
    d.index = d.hit_ro ? ro[ADDR_LSB +: 6] : off[ADDR_LSB +: 6];
    d.err = !(d.hit_rw || d.hit_ro);
    return d;
  endfunction
endpackage

// File: rtl/axil_reg_responder.sv
// axil_reg_responder: AXI4-Lite slave fronting R/W control registers and read-only status inputs
module axil_reg_responder
  import axil_reg_pkg::*;
#(
  parameter int NUM_RW_REGS = 8,
  parameter int NUM_RO_REGS = 8,
  parameter logic [NUM_RW_REGS*32-1:0] RW_RESET_VAL = '0,
  parameter int DECODE_BITS = 12
) (
  input  logic                      axil_clk,
  input  logic                      axil_rst,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [31:0]               s_axil_awaddr,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  input  logic [31:0]               s_axil_wdata,
  output logic                      s_axil_bvalid,
  output logic [1:0]                s_axil_bresp,
  input  logic                      s_axil_bready,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  input  logic [31:0]               s_axil_araddr,
  output logic                      s_axil_rvalid,
  output logic [31:0]               s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  input  logic                      s_axil_rready,
  output logic [NUM_RW_REGS*32-1:0] ctrl_regs,
  output logic [NUM_RW_REGS-1:0]    ctrl_wr_stb,
  input  logic [NUM_RO_REGS*32-1:0] stat_regs
);
  localparam logic [31:0] DMASK = (32'd1 << DECODE_BITS) - 32'd1;
  wr_state_e w_state, w_next;
  rd_state_e r_state, r_next;
  logic aw_held, w_held, aw_fire, w_fire, commit, ar_fire;
  logic [31:0] aw_addr, w_data, wa, wd, rd_val;
  logic [31:0] regs [NUM_RW_REGS];
  dec_t wdec, rdec;

  for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_out
    assign ctrl_regs[32*g +: 32] = regs[g];
  end

  // Write channel: independent AW/W capture, commit once both are present, then hold B until accepted
  always_comb begin
    s_axil_awready = w_state == W_IDLE && !aw_held && !axil_rst;
    s_axil_wready = w_state == W_IDLE && !w_held && !axil_rst;
    s_axil_bvalid = w_state == W_RESP;
    aw_fire = s_axil_awvalid && s_axil_awready;
    w_fire = s_axil_wvalid && s_axil_wready;
    commit = w_state == W_IDLE && (aw_held || aw_fire) && (w_held || w_fire);
    wa = aw_held ? aw_addr : s_axil_awaddr;
    wd = w_held ? w_data : s_axil_wdata;
    wdec = decode(wa, DMASK, 32'(NUM_RW_REGS), 32'(NUM_RO_REGS));
    w_next = commit ? W_RESP : (s_axil_bvalid && s_axil_bready) ? W_IDLE : w_state;
  end

  // Read channel: accept AR when idle and mux the addressed register into the response
  always_comb begin
    s_axil_arready = r_state == R_IDLE && !axil_rst;
    s_axil_rvalid = r_state == R_DATA;
    ar_fire = s_axil_arvalid && s_axil_arready;
    rdec = decode(s_axil_araddr, DMASK, 32'(NUM_RW_REGS), 32'(NUM_RO_REGS));
    rd_val = '0;
    for (int i = 0; i < NUM_RW_REGS; i++) if (rdec.hit_rw && rdec.index == 6'(i)) rd_val = regs[i];
    for (int j = 0; j < NUM_RO_REGS; j++) if (rdec.hit_ro && rdec.index == 6'(j)) rd_val = stat_regs[32*j +: 32];
    r_next = ar_fire ? R_DATA : (s_axil_rvalid && s_axil_rready) ? R_IDLE : r_state;
  end

  // FSM state registers
  always_ff @(posedge axil_clk) begin
    w_state <= axil_rst ? W_IDLE : w_next;
    r_state <= axil_rst ? R_IDLE : r_next;
  end

  // Write datapath: captured AW/W, register bank, strobes and write response
  always_ff @(posedge axil_clk) begin
    if (axil_rst) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      s_axil_bresp <= RESP_OKAY;
      ctrl_wr_stb <= '0;
      for (int i = 0; i < NUM_RW_REGS; i++) regs[i] <= RW_RESET_VAL[32*i +: 32];
    end else begin
      ctrl_wr_stb <= '0;
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_addr <= s_axil_awaddr;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s_axil_bresp <= (wdec.err || wdec.hit_ro) ? RESP_SLVERR : RESP_OKAY;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
          if (wdec.hit_rw && wdec.index == 6'(i)) begin
            regs[i] <= wd;
            ctrl_wr_stb[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Read datapath: data and response are snapshotted at AR acceptance and held until R handshake
  always_ff @(posedge axil_clk) begin
    if (axil_rst) begin
      s_axil_rdata <= '0;
      s_axil_rresp <= RESP_OKAY;
    end else if (ar_fire) begin
      s_axil_rdata <= rd_val;
      s_axil_rresp <= rdec.err ? RESP_SLVERR : RESP_OKAY;
    end
  end
endmodule

// File: doc/axil_reg_responder.md
Name: axil_reg_responder

Overview:
- AXI4-Lite slave (responder) terminating the single-master AXI-Lite bus that the 3-to-1 configuration crossbar drives.
- Decodes word addresses into a bank of read/write control registers and a bank of read-only status inputs.
- Returns OKAY/SLVERR responses and raises a one-cycle write strobe per control register for downstream RDMA logic.
- Stands in for the RDMA register space in simulation; intended for reuse as a generic register front-end.

Parameters:
- NUM_RW_REGS, 8, number of 32-bit R/W control registers at offsets 0x000 + 4*i (1..64).
- NUM_RO_REGS, 8, number of 32-bit read-only status registers at offsets 0x100 + 4*j (1..64).
- RW_RESET_VAL, '0, packed NUM_RW_REGS*32-bit reset value; register i uses bits [32*i +: 32].
- DECODE_BITS, 12, low address bits decoded; upper address bits are ignored (aliasing allowed).

Ports:
- axil_clk  in  1  clock
- axil_rst  in  1  synchronous active-high reset
- s_axil_awvalid/awready  in/out  1  write address handshake
- s_axil_awaddr  in  32  write byte address
- s_axil_wvalid/wready  in/out  1  write data handshake
- s_axil_wdata  in  32  write data (full word, no strobes)
- s_axil_bvalid  out  1  write response valid
- s_axil_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- s_axil_bready  in  1  write response accept
- s_axil_arvalid/arready  in/out  1  read address handshake
- s_axil_araddr  in  32  read byte address
- s_axil_rvalid  out  1  read data valid
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response, same encoding as bresp
- s_axil_rready  in  1  read data accept
- ctrl_regs  out  NUM_RW_REGS*32  current control register contents
- ctrl_wr_stb  out  NUM_RW_REGS  one-cycle pulse on a committed write to register i
- stat_regs  in  NUM_RO_REGS*32  status values, register j at [32*j +: 32]

Behaviour:
- Reset (axil_rst high at a clock edge):
  - all ready and valid outputs go to 0; bresp, rresp and rdata go to 0; ctrl_wr_stb goes to 0.
  - ctrl_regs load RW_RESET_VAL; any captured address or data is discarded.
  - A reset in the middle of a transaction drops it with no response and no register update.
  - Ready outputs are held low while axil_rst is high.
- Address decode, offset = addr[DECODE_BITS-1:0]:
  - offset[1:0] != 0 -> SLVERR.
  - offset < 4*NUM_RW_REGS -> RW register offset>>2.
  - 0x100 <= offset < 0x100 + 4*NUM_RO_REGS -> RO register (offset-0x100)>>2.
  - Any other offset -> SLVERR.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready = !aw_held and wready = !w_held. AW and W are each captured independently, in either order or in the same cycle.
  - When both are held, the write commits at that edge and the FSM moves to W_RESP:
    - RW hit: register updated and ctrl_wr_stb[i] pulses for exactly 1 cycle; bresp = OKAY.
    - RO hit or decode error: no state change and no strobe; bresp = SLVERR.
  - W_RESP: bvalid = 1, bresp stable, awready = wready = 0. On bvalid && bready, return to W_IDLE with aw_held and w_held cleared.
  - Latency: AW and W accepted together in cycle N gives bvalid in cycle N+1 and ctrl_regs updated in N+1. The earliest next AW/W acceptance is the cycle after the B handshake.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready = 1. On arvalid, rdata and rresp are registered and the FSM moves to R_DATA.
  - Status values are snapshotted at the acceptance edge.
  - Decode error returns rdata = 0 with SLVERR.
  - R_DATA: rvalid = 1, arready = 0; rdata and rresp are held stable until rready; on the handshake, return to R_IDLE.
  - Latency: AR accepted in cycle N gives rvalid in N+1; one transaction outstanding per channel.
- Read and write channels are fully independent and may complete in the same cycle.
- A read accepted in the same cycle as a write commit to the same RW register returns the pre-write value.
- Back-pressure: a master holding bready or rready low stalls only its own channel indefinitely, with no loss of data.

Decomposition:
- Package axil_reg_pkg holds:
  - resp codes RESP_OKAY and RESP_SLVERR;
  - constants RO_BASE_OFFSET = 12'h100 and ADDR_LSB = 2;
  - enums wr_state_e {W_IDLE, W_RESP} and rd_state_e {R_IDLE, R_DATA};
  - a decode function returning {hit_rw, hit_ro, index, err}.
- No sub-module: the two FSMs share only the decode function and the register array, so both FSMs and the register array stay in one module.

Test Plan:
1. AW, W (addr 0x008, data 0xA5A5_1234) in the same cycle; bready = 1 -> bvalid next cycle with OKAY; ctrl_regs[2] = 0xA5A5_1234; ctrl_wr_stb = 8'b0000_0100 for 1 cycle.
2. W at cycle 0 and AW at cycle 3 (addr 0x01C); bready held low 5 cycles -> awready low after capture; bvalid held with bresp stable until bready; ctrl_regs[7] updated at cycle 4.
3. stat_regs[3] = 0xCAFEF00D; read 0x10C with rready low 4 cycles -> rvalid one cycle after AR; rdata = 0xCAFEF00D, OKAY, held stable; arready = 0 until the handshake.
4. Write to 0x104, write to 0x00A (unaligned), read from 0x200 -> each returns SLVERR; read rdata = 0; ctrl_regs unchanged; no ctrl_wr_stb pulse.
5. Write 0x1111_1111 to 0x000 committing in the same cycle as a read of 0x000 is accepted -> read returns the old value (RW_RESET_VAL word 0); a follow-up read returns 0x1111_1111.
6. Assert axil_rst while in W_RESP and R_DATA -> next cycle bvalid = rvalid = 0, all readies 0 while reset is high, ctrl_regs = RW_RESET_VAL; after release, a fresh write completes normally.
